seg_digit_drawer: RTL

- Draws a single seven-segment-style glyph (0-9, optionally A-F) as a stream of one-pixel-per-cycle plot coordinates for the VGA pixel writer.
- Successor to the fixed per-digit line drawers. Segment length, height, offsets and hex mode are parameters, and the glyph is selected at run time.
- Uses a start/busy/done handshake so the board renderer can sequence tiles.
- Sits between the tile renderer (which supplies the tile origin and value) and the framebuffer write port.

---
 rtl/pixel_draw_pkg.sv | 34 +++
 rtl/seg_decoder.sv | 17 +
 rtl/seg_digit_drawer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/pixel_draw_pkg.sv
// Shared types and constants for the seven-segment pixel drawers.
// Segment masks use bit order gfedcba (bit 0 = segment a).
package pixel_draw_pkg;

  localparam int DEF_X_W = 8;
  localparam int DEF_Y_W = 7;

  typedef enum logic [2:0] {
    SEG_A = 3'd0,
    SEG_B = 3'd1,
    SEG_C = 3'd2,
    SEG_D = 3'd3,
    SEG_E = 3'd4,
    SEG_F = 3'd5,
    SEG_G = 3'd6
  } seg_idx_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_FIN  = 2'd2
  } draw_state_e;

  // Entries 10-15 hold the hex glyphs A, b, C, d, E, F.
  localparam logic [6:0] SEG_MASK_TBL [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic seg_is_horiz(input seg_idx_e seg);
    return (seg == SEG_A) || (seg == SEG_D) || (seg == SEG_G);
  endfunction

endpackage

// File: rtl/seg_decoder.sv
// Combinational glyph decoder: 4-bit value to gfedcba segment mask.
// With HEX_EN=0 the values 10-15 decode to an empty (blank) mask.
module seg_decoder
  import pixel_draw_pkg::*;
#(
  parameter bit HEX_EN = 1'b0
) (
  input  logic [3:0] digit,
  output logic [6:0] mask
);

  always_comb begin
    mask = SEG_MASK_TBL[digit];
    if (!HEX_EN && (digit > 4'd9)) mask = 7'h00;
  end

endmodule

// File: rtl/seg_digit_drawer.sv
// Streams one seven-segment glyph as plot coordinates, one pixel per cycle.
// Handshake: start is taken only in IDLE; busy covers the draw; done pulses once.
module seg_digit_drawer
  import pixel_draw_pkg::*;
#(
  parameter int X_W     = DEF_X_W,
  parameter int Y_W     = DEF_Y_W,
  parameter int SEG_LEN = 5,
  parameter int SEG_H   = 7,
  parameter int OFF_X   = 11,
  parameter int OFF_Y   = 7,
  parameter bit HEX_EN  = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [3:0]     digit,
  input  logic [X_W-1:0] xIn,
  input  logic [Y_W-1:0] yIn,
  output logic [X_W-1:0] xOut,
  output logic [Y_W-1:0] yOut,
  output logic           plot,
  output logic           busy,
  output logic           done
);

  localparam int STEP_MAX = (SEG_LEN > SEG_H) ? SEG_LEN : SEG_H;
  localparam int STEP_W   = (STEP_MAX < 1) ? 1 : $clog2(STEP_MAX + 1);

  draw_state_e       state_q, state_d;
  logic [6:0]        mask_q, mask_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [X_W-1:0]    ox_q, ox_d, xout_q, xout_d;
  logic [Y_W-1:0]    oy_q, oy_d, yout_q, yout_d;
  logic              plot_q, plot_d, busy_q, busy_d, done_q, done_d;

  logic [6:0]        dec_mask;
  logic [6:0]        src_mask, seg_bit;
  logic [X_W-1:0]    src_ox, pix_x;
  logic [Y_W-1:0]    src_oy, pix_y;
  logic [STEP_W-1:0] src_step;
  seg_idx_e          cur_seg;
  logic              step_last, emit;

  seg_decoder #(.HEX_EN(HEX_EN)) u_dec (
    .digit(digit),
    .mask (dec_mask)
  );

  // In IDLE the first pixel comes straight from the inputs so it is valid
  // the cycle after acceptance; afterwards everything runs off latched state.
  always_comb begin
    if (state_q == ST_IDLE) begin
      src_mask = dec_mask;
      src_ox   = xIn + X_W'(OFF_X);
      src_oy   = yIn + Y_W'(OFF_Y);
      src_step = '0;
    end else begin
      src_mask = mask_q;
      src_ox   = ox_q;
      src_oy   = oy_q;
      src_step = step_q;
    end

    cur_seg = SEG_A;
    for (int i = 6; i >= 0; i--) begin
      if (src_mask[i]) cur_seg = seg_idx_e'(3'(i));
    end
    seg_bit = 7'b1 << cur_seg;

    step_last = seg_is_horiz(cur_seg) ? (src_step == STEP_W'(SEG_LEN))
                                      : (src_step == STEP_W'(SEG_H));

    case (cur_seg)
      SEG_A: begin pix_x = src_ox + X_W'(src_step); pix_y = src_oy; end
      SEG_B: begin pix_x = src_ox + X_W'(SEG_LEN);  pix_y = src_oy + Y_W'(src_step); end
      SEG_C: begin pix_x = src_ox + X_W'(SEG_LEN);  pix_y = src_oy + Y_W'(SEG_H) + Y_W'(src_step); end
      SEG_D: begin pix_x = src_ox + X_W'(src_step); pix_y = src_oy + Y_W'(2 * SEG_H); end
      SEG_E: begin pix_x = src_ox;                  pix_y = src_oy + Y_W'(SEG_H) + Y_W'(src_step); end
      SEG_F: begin pix_x = src_ox;                  pix_y = src_oy + Y_W'(src_step); end
      default: begin pix_x = src_ox + X_W'(src_step); pix_y = src_oy + Y_W'(SEG_H); end
    endcase
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    step_d  = step_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    xout_d  = xout_q;
    yout_d  = yout_q;
    plot_d  = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    emit    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mask_d = dec_mask;
          ox_d   = src_ox;
          oy_d   = src_oy;
          step_d = '0;
          busy_d = 1'b1;
          if (dec_mask == 7'h00) begin
            state_d = ST_FIN;
            done_d  = 1'b1;
          end else begin
            emit = 1'b1;
          end
        end
      end
      ST_DRAW: begin
        // An empty mask here means the final pixel went out last cycle.
        if (mask_q == 7'h00) begin
          state_d = ST_FIN;
          done_d  = 1'b1;
        end else begin
          emit = 1'b1;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    if (emit) begin
      state_d = ST_DRAW;
      xout_d  = pix_x;
      yout_d  = pix_y;
      plot_d  = 1'b1;
      if (step_last) begin
        mask_d = src_mask & ~seg_bit;
        step_d = '0;
      end else begin
        mask_d = src_mask;
        step_d = src_step + STEP_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      step_q  <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      xout_q  <= '0;
      yout_q  <= '0;
      plot_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      step_q  <= step_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      xout_q  <= xout_d;
      yout_q  <= yout_d;
      plot_q  <= plot_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign xOut = xout_q;
  assign yOut = yout_q;
  assign plot = plot_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
